sweep_counter: RTL and testbench

- Parametrised successor to the fixed 12-bit saturating counter that drives the binary-to-BCD display path.
- Counts between programmable bounds in up, down or bounce mode, with saturate-or-wrap selection, hold, abort, and a terminal-count pulse.
- Sits upstream of the BCD converter/display logic and supplies its `count` value plus `done` and `tc` status.

---
 rtl/sweep_pkg.sv | 24 ++
 rtl/sweep_prescaler.sv | 32 +++
 rtl/sweep_counter.sv | 133 +++++++++++++
 tb/tb_sweep_counter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/sweep_pkg.sv
// Shared encodings and default widths for the sweep counter block.
package sweep_pkg;

  localparam int unsigned DEF_WIDTH      = 12;
  localparam int unsigned DEF_PRESCALE_W = 16;

  typedef enum logic [1:0] {
    MODE_UP     = 2'b00,
    MODE_DOWN   = 2'b01,
    MODE_BOUNCE = 2'b10
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // The unused mode code 2'b11 counts up.
  function automatic mode_e norm_mode(input logic [1:0] m);
    return (m == 2'b11) ? MODE_UP : mode_e'(m);
  endfunction

endpackage

// File: rtl/sweep_prescaler.sv
// Tick generator for the sweep counter: one tick every div+1 enabled cycles.
// Only built when SWEEP_COUNTER_PRESCALE_EN is defined.
`ifdef SWEEP_COUNTER_PRESCALE_EN
module sweep_prescaler
  import sweep_pkg::*;
#(
  parameter int unsigned W = DEF_PRESCALE_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] div,
  output logic         tick_c
);

  logic [W-1:0] cnt;

  assign tick_c = en && (cnt == div);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick_c ? '0 : cnt + W'(1);
    end
  end

endmodule
`endif

// File: rtl/sweep_counter.sv
// Programmable-bound up/down/bounce counter feeding the BCD display path.
// Optional prescaler enabled by defining SWEEP_COUNTER_PRESCALE_EN.
module sweep_counter
  import sweep_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned PRESCALE_W = DEF_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  hold,
  input  logic [1:0]            mode,
  input  logic                  wrap,
  input  logic [WIDTH-1:0]      lo,
  input  logic [WIDTH-1:0]      hi,
  input  logic [PRESCALE_W-1:0] div,
  output logic [WIDTH-1:0]      count,
  output logic                  busy,
  output logic                  done,
  output logic                  tc,
  output logic                  dir,
  output logic                  err
);

  state_e           state;
  mode_e            cfg_mode;
  logic             cfg_wrap;
  logic [WIDTH-1:0] cfg_lo;
  logic [WIDTH-1:0] cfg_hi;
  logic             tick_c;
  logic             at_term_c;
  logic             bounce_turn_c;
  mode_e            mode_n_c;

`ifdef SWEEP_COUNTER_PRESCALE_EN
  logic [PRESCALE_W-1:0] cfg_div;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cfg_div <= '0;
    end else if (start && !abort) begin
      cfg_div <= div;
    end
  end

  sweep_prescaler #(.W(PRESCALE_W)) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .clr    (start || abort),
    .en     ((state == ST_RUN) && !hold),
    .div    (cfg_div),
    .tick_c (tick_c)
  );
`else
  logic unused_div;
  assign unused_div = ^div;
  assign tick_c     = 1'b1;
`endif

  assign mode_n_c      = norm_mode(mode);
  assign at_term_c     = dir ? (count == cfg_lo) : (count == cfg_hi);
  // Degenerate lo==hi bounce has no room to turn; treat it as up/down.
  assign bounce_turn_c = (cfg_mode == MODE_BOUNCE) && (cfg_lo != cfg_hi);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      cfg_mode <= MODE_UP;
      cfg_wrap <= 1'b0;
      cfg_lo   <= '0;
      cfg_hi   <= '0;
      count    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      tc       <= 1'b0;
      dir      <= 1'b0;
      err      <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (abort) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
        done  <= 1'b0;
      end else if (start) begin
        if (lo > hi) begin
          state <= ST_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          err   <= 1'b1;
        end else begin
          state    <= ST_RUN;
          busy     <= 1'b1;
          done     <= 1'b0;
          err      <= 1'b0;
          cfg_mode <= mode_n_c;
          cfg_wrap <= wrap;
          cfg_lo   <= lo;
          cfg_hi   <= hi;
          if (mode_n_c == MODE_DOWN) begin
            count <= hi;
            dir   <= 1'b1;
          end else begin
            count <= lo;
            dir   <= 1'b0;
          end
        end
      end else if ((state == ST_RUN) && tick_c && !hold) begin
        if (!at_term_c) begin
          count <= dir ? count - WIDTH'(1) : count + WIDTH'(1);
        end else if (bounce_turn_c && !dir) begin
          dir   <= 1'b1;
          count <= cfg_hi - WIDTH'(1);
        end else if (cfg_wrap) begin
          tc <= 1'b1;
          if (bounce_turn_c) begin
            dir   <= 1'b0;
            count <= cfg_lo + WIDTH'(1);
          end else begin
            count <= dir ? cfg_hi : cfg_lo;
          end
        end else begin
          tc    <= 1'b1;
          state <= ST_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sweep_counter.sv
// Directed-vector bench for sweep_counter: table of per-cycle vectors plus
// hand sequences for the full sweep, hold and (when enabled) prescale.
module tb_sweep_counter;

  localparam int unsigned W  = 12;
  localparam int unsigned PW = 16;

  logic          clk = 1'b0;
  logic          rst, start, abort, hold, wrap;
  logic [1:0]    mode;
  logic [W-1:0]  lo, hi;
  logic [PW-1:0] div;
  logic [W-1:0]  count;
  logic          busy, done, tc, dir, err;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic         rst, start, abort, hold;
    logic [1:0]   mode;
    logic         wrap;
    logic [W-1:0] lo, hi;
    logic [W-1:0] e_count;
    logic         e_busy, e_done, e_tc, e_dir, e_err;
  } vec_t;

  vec_t vecs[$];

  sweep_counter #(.WIDTH(W), .PRESCALE_W(PW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .hold(hold),
    .mode(mode), .wrap(wrap), .lo(lo), .hi(hi), .div(div),
    .count(count), .busy(busy), .done(done), .tc(tc), .dir(dir), .err(err)
  );

  always #5 clk = ~clk;

  function automatic vec_t v(input logic r, s, a, h, input logic [1:0] m,
                             input logic wr, input int l, input int hh,
                             input int ec, input logic eb, ed, et, edr, ee);
    vec_t x;
    x.rst = r; x.start = s; x.abort = a; x.hold = h; x.mode = m; x.wrap = wr;
    x.lo = W'(l); x.hi = W'(hh); x.e_count = W'(ec);
    x.e_busy = eb; x.e_done = ed; x.e_tc = et; x.e_dir = edr; x.e_err = ee;
    return x;
  endfunction

  task automatic drive(input logic r, s, a, h, input logic [1:0] m,
                       input logic wr, input int l, input int hh);
    rst = r; start = s; abort = a; hold = h; mode = m; wrap = wr;
    lo = W'(l); hi = W'(hh);
  endtask

  task automatic check(input string name, input int ec,
                       input logic eb, ed, et, edr, ee);
    n_vec++;
    if (count !== W'(ec) || busy !== eb || done !== ed || tc !== et ||
        dir !== edr || err !== ee) begin
      n_err++;
      $display("FAIL %s: got count=%0d busy=%b done=%b tc=%b dir=%b err=%b, want count=%0d busy=%b done=%b tc=%b dir=%b err=%b",
               name, count, busy, done, tc, dir, err, ec, eb, ed, et, edr, ee);
    end
  endtask

  // Advance one edge and sample away from it.
  task automatic step_chk(input string name, input int ec,
                          input logic eb, ed, et, edr, ee);
    @(posedge clk);
    #1;
    check(name, ec, eb, ed, et, edr, ee);
  endtask

  initial begin
    div = '0;
    drive(0, 0, 0, 0, 2'b00, 0, 0, 0);

    // reset
    vecs.push_back(v(0,0,0,0,2'b00,0, 0,0,    0,0,0,0,0,0));
    vecs.push_back(v(0,0,0,0,2'b00,0, 0,0,    0,0,0,0,0,0));
    // wrap up 10..13
    vecs.push_back(v(1,1,0,0,2'b00,1,10,13,  10,1,0,0,0,0));
    vecs.push_back(v(1,0,0,0,2'b00,1,10,13,  11,1,0,0,0,0));
    vecs.push_back(v(1,0,0,0,2'b00,1,10,13,  12,1,0,0,0,0));
    vecs.push_back(v(1,0,0,0,2'b00,1,10,13,  13,1,0,0,0,0));
    vecs.push_back(v(1,0,0,0,2'b00,1,10,13,  10,1,0,1,0,0));
    vecs.push_back(v(1,0,0,0,2'b00,1,10,13,  11,1,0,0,0,0));
    vecs.push_back(v(1,0,0,0,2'b00,1,10,13,  12,1,0,0,0,0));
    vecs.push_back(v(1,0,0,0,2'b00,1,10,13,  13,1,0,0,0,0));
    vecs.push_back(v(1,0,0,0,2'b00,1,10,13,  10,1,0,1,0,0));
    vecs.push_back(v(1,0,0,0,2'b01,0, 0,100, 11,1,0,0,0,0));
    // bounce 2..5 wrap
    vecs.push_back(v(1,1,0,0,2'b10,1, 2,5,    2,1,0,0,0,0));
    vecs.push_back(v(1,0,0,0,2'b10,1, 2,5,    3,1,0,0,0,0));
    vecs.push_back(v(1,0,0,0,2'b10,1, 2,5,    4,1,0,0,0,0));
    vecs.push_back(v(1,0,0,0,2'b10,1, 2,5,    5,1,0,0,0,0));
    vecs.push_back(v(1,0,0,0,2'b10,1, 2,5,    4,1,0,0,1,0));
    vecs.push_back(v(1,0,0,0,2'b10,1, 2,5,    3,1,0,0,1,0));
    vecs.push_back(v(1,0,0,0,2'b10,1, 2,5,    2,1,0,0,1,0));
    vecs.push_back(v(1,0,0,0,2'b10,1, 2,5,    3,1,0,1,0,0));
    vecs.push_back(v(1,0,0,0,2'b10,1, 2,5,    4,1,0,0,0,0));
    // lo==hi bounce wrap
    vecs.push_back(v(1,1,0,0,2'b10,1, 7,7,    7,1,0,0,0,0));
    vecs.push_back(v(1,0,0,0,2'b10,1, 7,7,    7,1,0,1,0,0));
    vecs.push_back(v(1,0,0,0,2'b10,1, 7,7,    7,1,0,1,0,0));
    // bad config
    vecs.push_back(v(1,1,0,0,2'b00,0, 9,3,    7,0,1,0,0,1));
    vecs.push_back(v(1,0,0,0,2'b00,0, 9,3,    7,0,1,0,0,1));
    // down saturate 5..3
    vecs.push_back(v(1,1,0,0,2'b01,0, 3,5,    5,1,0,0,1,0));
    vecs.push_back(v(1,0,0,0,2'b01,0, 3,5,    4,1,0,0,1,0));
    vecs.push_back(v(1,0,0,0,2'b01,0, 3,5,    3,1,0,0,1,0));
    vecs.push_back(v(1,0,0,0,2'b01,0, 3,5,    3,0,1,1,1,0));
    vecs.push_back(v(1,0,0,0,2'b01,0, 3,5,    3,0,1,0,1,0));
    // abort + start together
    vecs.push_back(v(1,1,0,0,2'b00,0, 0,9,    0,1,0,0,0,0));
    vecs.push_back(v(1,0,0,0,2'b00,0, 0,9,    1,1,0,0,0,0));
    vecs.push_back(v(1,1,1,0,2'b00,0, 5,9,    1,0,0,0,0,0));
    vecs.push_back(v(1,0,0,0,2'b00,0, 5,9,    1,0,0,0,0,0));
    // mode 11 as up, saturate, hold vs start/abort
    vecs.push_back(v(1,1,0,0,2'b11,0, 0,2,    0,1,0,0,0,0));
    vecs.push_back(v(1,0,0,1,2'b11,0, 0,2,    0,1,0,0,0,0));
    vecs.push_back(v(1,0,0,0,2'b11,0, 0,2,    1,1,0,0,0,0));
    vecs.push_back(v(1,0,0,0,2'b11,0, 0,2,    2,1,0,0,0,0));
    vecs.push_back(v(1,0,0,0,2'b11,0, 0,2,    2,0,1,1,0,0));
    vecs.push_back(v(1,1,0,1,2'b11,0, 0,2,    0,1,0,0,0,0));
    vecs.push_back(v(1,0,0,1,2'b11,0, 0,2,    0,1,0,0,0,0));
    vecs.push_back(v(1,0,1,1,2'b11,0, 0,2,    0,0,0,0,0,0));
    // down wrap 6..4
    vecs.push_back(v(1,1,0,0,2'b01,1, 4,6,    6,1,0,0,1,0));
    vecs.push_back(v(1,0,0,0,2'b01,1, 4,6,    5,1,0,0,1,0));
    vecs.push_back(v(1,0,0,0,2'b01,1, 4,6,    4,1,0,0,1,0));
    vecs.push_back(v(1,0,0,0,2'b01,1, 4,6,    6,1,0,1,1,0));
    vecs.push_back(v(1,0,0,0,2'b01,1, 4,6,    5,1,0,0,1,0));
    // restart during RUN
    vecs.push_back(v(1,1,0,0,2'b00,0,20,21,  20,1,0,0,0,0));
    vecs.push_back(v(1,0,0,0,2'b00,0,20,21,  21,1,0,0,0,0));
    vecs.push_back(v(1,0,0,0,2'b00,0,20,21,  21,0,1,1,0,0));
    // bounce saturate 0..1
    vecs.push_back(v(1,1,0,0,2'b10,0, 0,1,    0,1,0,0,0,0));
    vecs.push_back(v(1,0,0,0,2'b10,0, 0,1,    1,1,0,0,0,0));
    vecs.push_back(v(1,0,0,0,2'b10,0, 0,1,    0,1,0,0,1,0));
    vecs.push_back(v(1,0,0,0,2'b10,0, 0,1,    0,0,1,1,1,0));
    // reset mid-sweep
    vecs.push_back(v(1,1,0,0,2'b00,1,100,200,100,1,0,0,0,0));
    vecs.push_back(v(1,0,0,0,2'b00,1,100,200,101,1,0,0,0,0));
    vecs.push_back(v(0,0,0,0,2'b00,1,100,200,  0,0,0,0,0,0));
    // top-of-range wrap
    vecs.push_back(v(1,1,0,0,2'b00,1,4094,4095,4094,1,0,0,0,0));
    vecs.push_back(v(1,0,0,0,2'b00,1,4094,4095,4095,1,0,0,0,0));
    vecs.push_back(v(1,0,0,0,2'b00,1,4094,4095,4094,1,0,1,0,0));
    // lo==hi up saturate
    vecs.push_back(v(1,1,0,0,2'b00,0,50,50,  50,1,0,0,0,0));
    vecs.push_back(v(1,0,0,0,2'b00,0,50,50,  50,0,1,1,0,0));

    #2;
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].start, vecs[i].abort, vecs[i].hold,
            vecs[i].mode, vecs[i].wrap, int'(vecs[i].lo), int'(vecs[i].hi));
      step_chk($sformatf("vec%0d", i), int'(vecs[i].e_count), vecs[i].e_busy,
               vecs[i].e_done, vecs[i].e_tc, vecs[i].e_dir, vecs[i].e_err);
    end

    // full 0..4095 saturating sweep after a 2-cycle reset
    drive(0, 0, 0, 0, 2'b00, 0, 0, 4095);
    step_chk("full_rst0", 0, 0, 0, 0, 0, 0);
    step_chk("full_rst1", 0, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 2'b00, 0, 0, 4095);
    step_chk("full_start", 0, 1, 0, 0, 0, 0);
    start = 1'b0;
    for (int k = 1; k <= 4095; k++) step_chk("full_step", k, 1, 0, 0, 0, 0);
    step_chk("full_term", 4095, 0, 1, 1, 0, 0);
    step_chk("full_held", 4095, 0, 1, 0, 0, 0);

    // hold freezes count for 5 cycles mid-sweep
    drive(1, 1, 0, 0, 2'b00, 1, 0, 100);
    step_chk("hold_start", 0, 1, 0, 0, 0, 0);
    start = 1'b0;
    for (int k = 1; k <= 3; k++) step_chk("hold_pre", k, 1, 0, 0, 0, 0);
    hold = 1'b1;
    for (int k = 0; k < 5; k++) step_chk("hold_frozen", 3, 1, 0, 0, 0, 0);
    hold = 1'b0;
    step_chk("hold_release", 4, 1, 0, 0, 0, 0);

`ifdef SWEEP_COUNTER_PRESCALE_EN
    // div=3: a step every 4 cycles, stretched by hold
    div = PW'(3);
    drive(1, 1, 0, 0, 2'b00, 1, 0, 2);
    step_chk("pre_start", 0, 1, 0, 0, 0, 0);
    start = 1'b0;
    for (int k = 0; k < 3; k++) step_chk("pre_wait0", 0, 1, 0, 0, 0, 0);
    step_chk("pre_step1", 1, 1, 0, 0, 0, 0);
    hold = 1'b1;
    for (int k = 0; k < 2; k++) step_chk("pre_hold", 1, 1, 0, 0, 0, 0);
    hold = 1'b0;
    for (int k = 0; k < 3; k++) step_chk("pre_wait1", 1, 1, 0, 0, 0, 0);
    step_chk("pre_step2", 2, 1, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) step_chk("pre_wait2", 2, 1, 0, 0, 0, 0);
    step_chk("pre_wrap", 0, 1, 0, 1, 0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
